// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencing controller: state encodings, key codes, counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package calc_pkg;

  // State encodings are visible on state_o, so the display mux depends on these exact values.
  typedef enum logic [2:0] {
    ST_ENT_A   = 3'b000,
    ST_ENT_B   = 3'b011,
    ST_CALC    = 3'b010,
    ST_RESULT  = 3'b110
  } state_t;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_ADD = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hD;
  localparam logic [3:0] KEY_RCL = 4'hE;
  localparam logic [3:0] KEY_STO = 4'hF;

  // Digit counters; wide enough for MAX_DIGITS up to 15.
  localparam int DIG_CNT_W = 4;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_SUB) || (k == KEY_ADD);
  endfunction

endpackage

// File: rtl/calc_watchdog.sv
// Cycle counter bounding how long the controller waits for the ALU.
// Latency: expire is combinational from the count; it asserts on the TIMEOUT-th enabled cycle after clear.
// Backpressure: none; clr has priority over en, and the count saturates at TIMEOUT-1.
// Ports: clk, rst_n (async, active low), clr (zero the count), en (advance the count),
//        expire (count has reached TIMEOUT-1 while enabled).
module calc_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: turns keypad events into one-cycle datapath strobes and waits on the ALU.
// Latency: every output is registered; strobes appear the cycle after the key is accepted.
// Backpressure: key_ready drops only while in CALC; every key accepted elsewhere is consumed, even if ignored.
// Ports: clk, rst_n; key_valid/key_code/key_ready (keypad handshake); state_o; digit with dig_wr_a/dig_wr_b;
//        clr_all, op_sub, rcl_a, rcl_b, mem_store, res_to_a, alu_start (datapath controls);
//        alu_done (ALU handshake); result_valid, err (status).
module calc_seq_ctrl #(
  parameter int MAX_DIGITS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [2:0] state_o,
  output logic [3:0] digit,
  output logic       dig_wr_a,
  output logic       dig_wr_b,
  output logic       clr_all,
  output logic       op_sub,
  output logic       rcl_a,
  output logic       rcl_b,
  output logic       mem_store,
  output logic       res_to_a,
  output logic       alu_start,
  input  logic       alu_done,
  output logic       result_valid,
  output logic       err
);
  import calc_pkg::*;

  localparam logic [DIG_CNT_W-1:0] MAXD = DIG_CNT_W'(MAX_DIGITS);

  state_t               state_q, state_d;
  logic [DIG_CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                 op_sub_d, err_d;
  logic [3:0]           digit_d;
  logic                 dig_wr_a_d, dig_wr_b_d, clr_all_d, rcl_a_d, rcl_b_d;
  logic                 mem_store_d, res_to_a_d, alu_start_d;
  logic                 accept, in_calc, wd_expire;

  assign accept  = key_valid & key_ready;
  assign in_calc = (state_q == ST_CALC);
  assign state_o = state_q;

  calc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!in_calc),
    .en     (in_calc),
    .expire (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    op_sub_d    = op_sub;
    err_d       = err;
    digit_d     = digit;
    dig_wr_a_d  = 1'b0;
    dig_wr_b_d  = 1'b0;
    clr_all_d   = 1'b0;
    rcl_a_d     = 1'b0;
    rcl_b_d     = 1'b0;
    mem_store_d = 1'b0;
    res_to_a_d  = 1'b0;
    alu_start_d = 1'b0;

    if (accept) err_d = 1'b0;

    if (in_calc) begin
      // alu_done is checked first so a done arriving on the expiry cycle is not flagged as an error.
      if (alu_done) begin
        state_d = ST_RESULT;
      end else if (wd_expire) begin
        err_d   = 1'b1;
        state_d = ST_RESULT;
      end
    end else if (accept) begin
      if (key_code == KEY_CLR) begin
        clr_all_d = 1'b1;
        cnt_a_d   = '0;
        cnt_b_d   = '0;
        op_sub_d  = 1'b0;
        state_d   = ST_ENT_A;
      end else begin
        case (state_q)
          ST_ENT_A: begin
            if (is_digit(key_code)) begin
              if (cnt_a_q < MAXD) begin
                dig_wr_a_d = 1'b1;
                digit_d    = key_code;
                cnt_a_d    = cnt_a_q + 1'b1;
              end
            end else if (is_op(key_code)) begin
              op_sub_d = (key_code == KEY_SUB);
              cnt_b_d  = '0;
              state_d  = ST_ENT_B;
            end else if (key_code == KEY_RCL) begin
              rcl_a_d = 1'b1;
              cnt_a_d = MAXD;
            end else if (key_code == KEY_STO) begin
              mem_store_d = 1'b1;
            end
          end
          ST_ENT_B: begin
            if (is_digit(key_code)) begin
              if (cnt_b_q < MAXD) begin
                dig_wr_b_d = 1'b1;
                digit_d    = key_code;
                cnt_b_d    = cnt_b_q + 1'b1;
              end
            end else if (is_op(key_code)) begin
              // Operator may be changed only before any B digit has been entered.
              if (cnt_b_q == '0) op_sub_d = (key_code == KEY_SUB);
            end else if (key_code == KEY_RCL) begin
              rcl_b_d = 1'b1;
              cnt_b_d = MAXD;
            end else if (key_code == KEY_EQ) begin
              if (cnt_b_q != '0) begin
                alu_start_d = 1'b1;
                state_d     = ST_CALC;
              end
            end
          end
          ST_RESULT: begin
            if (is_digit(key_code)) begin
              // A digit after a result starts a fresh calculation with that digit as A.
              clr_all_d  = 1'b1;
              dig_wr_a_d = 1'b1;
              digit_d    = key_code;
              cnt_a_d    = DIG_CNT_W'(1);
              state_d    = ST_ENT_A;
            end else if (is_op(key_code)) begin
              res_to_a_d = 1'b1;
              op_sub_d   = (key_code == KEY_SUB);
              cnt_b_d    = '0;
              state_d    = ST_ENT_B;
            end else if (key_code == KEY_STO) begin
              mem_store_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ENT_A;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      op_sub       <= 1'b0;
      err          <= 1'b0;
      digit        <= '0;
      key_ready    <= 1'b1;
      result_valid <= 1'b0;
      dig_wr_a     <= 1'b0;
      dig_wr_b     <= 1'b0;
      clr_all      <= 1'b0;
      rcl_a        <= 1'b0;
      rcl_b        <= 1'b0;
      mem_store    <= 1'b0;
      res_to_a     <= 1'b0;
      alu_start    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      op_sub       <= op_sub_d;
      err          <= err_d;
      digit        <= digit_d;
      key_ready    <= (state_d != ST_CALC);
      result_valid <= (state_d == ST_RESULT);
      dig_wr_a     <= dig_wr_a_d;
      dig_wr_b     <= dig_wr_b_d;
      clr_all      <= clr_all_d;
      rcl_a        <= rcl_a_d;
      rcl_b        <= rcl_b_d;
      mem_store    <= mem_store_d;
      res_to_a     <= res_to_a_d;
      alu_start    <= alu_start_d;
    end
  end

endmodule
